// File: rtl/cdb_broadcaster.sv
// Common data bus transmitter: buffers ALU and load results in per-producer FIFOs and broadcasts one per cycle, round-robin.
// Optional CDB_BYPASS_EN lets a result arriving while both FIFOs are empty skip its FIFO and go straight onto the bus.
`ifndef RoB_addr
`define RoB_addr 3:0
`endif

module cdb_broadcaster #(
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             alu_valid,
  input  logic [`RoB_addr] alu_RoBindex,
  input  logic [31:0]      alu_value,
  output logic             alu_full,
  input  logic             lsb_valid,
  input  logic [`RoB_addr] lsb_RoBindex,
  input  logic [31:0]      lsb_value,
  output logic             lsb_full,
  output logic             cdb_valid,
  output logic [`RoB_addr] cdb_RoBindex,
  output logic [31:0]      cdb_value
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [`RoB_addr]  alu_idx_mem [DEPTH];
  logic [31:0]       alu_val_mem [DEPTH];
  logic [`RoB_addr]  lsb_idx_mem [DEPTH];
  logic [31:0]       lsb_val_mem [DEPTH];

  logic [ADDR_W-1:0] alu_head, alu_tail, lsb_head, lsb_tail;
  logic [ADDR_W:0]   alu_cnt, lsb_cnt;
  logic              prefer_lsb;

  logic alu_ne, lsb_ne;
  logic grant_alu, grant_lsb;
  logic byp_alu, byp_lsb;
  logic alu_push, lsb_push;

  assign alu_full = (alu_cnt == FULL_CNT);
  assign lsb_full = (lsb_cnt == FULL_CNT);

  // Grants look only at the FIFO heads before the edge; the full flag ignores any same-edge pop.
  always_comb begin
    alu_ne    = (alu_cnt != '0);
    lsb_ne    = (lsb_cnt != '0);
    grant_alu = alu_ne && (!lsb_ne || !prefer_lsb);
    grant_lsb = lsb_ne && (!alu_ne || prefer_lsb);
`ifdef CDB_BYPASS_EN
    byp_alu   = !alu_ne && !lsb_ne && alu_valid && (!lsb_valid || !prefer_lsb);
    byp_lsb   = !alu_ne && !lsb_ne && lsb_valid && (!alu_valid || prefer_lsb);
`else
    byp_alu   = 1'b0;
    byp_lsb   = 1'b0;
`endif
    alu_push  = alu_valid && !alu_full && !byp_alu;
    lsb_push  = lsb_valid && !lsb_full && !byp_lsb;
  end

  // Storage arrays carry no reset; stale contents are unreachable once the pointers are cleared.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !clear) begin
      if (alu_push) begin
        alu_idx_mem[alu_tail] <= alu_RoBindex;
        alu_val_mem[alu_tail] <= alu_value;
      end
      if (lsb_push) begin
        lsb_idx_mem[lsb_tail] <= lsb_RoBindex;
        lsb_val_mem[lsb_tail] <= lsb_value;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      alu_head     <= '0;
      alu_tail     <= '0;
      alu_cnt      <= '0;
      lsb_head     <= '0;
      lsb_tail     <= '0;
      lsb_cnt      <= '0;
      prefer_lsb   <= 1'b0;
      cdb_valid    <= 1'b0;
      cdb_RoBindex <= '0;
      cdb_value    <= '0;
    end else if (clear) begin
      alu_head     <= '0;
      alu_tail     <= '0;
      alu_cnt      <= '0;
      lsb_head     <= '0;
      lsb_tail     <= '0;
      lsb_cnt      <= '0;
      prefer_lsb   <= 1'b0;
      cdb_valid    <= 1'b0;
      cdb_RoBindex <= '0;
      cdb_value    <= '0;
    end else if (rdy_in) begin
      if (alu_push) alu_tail <= alu_tail + PTR_ONE;
      if (grant_alu) alu_head <= alu_head + PTR_ONE;
      if (lsb_push) lsb_tail <= lsb_tail + PTR_ONE;
      if (grant_lsb) lsb_head <= lsb_head + PTR_ONE;

      case ({alu_push, grant_alu})
        2'b10:   alu_cnt <= alu_cnt + CNT_ONE;
        2'b01:   alu_cnt <= alu_cnt - CNT_ONE;
        default: alu_cnt <= alu_cnt;
      endcase
      case ({lsb_push, grant_lsb})
        2'b10:   lsb_cnt <= lsb_cnt + CNT_ONE;
        2'b01:   lsb_cnt <= lsb_cnt - CNT_ONE;
        default: lsb_cnt <= lsb_cnt;
      endcase

      // A bypass counts as a grant, so it moves the round-robin pointer the same way.
      if (grant_alu) begin
        cdb_valid    <= 1'b1;
        cdb_RoBindex <= alu_idx_mem[alu_head];
        cdb_value    <= alu_val_mem[alu_head];
        prefer_lsb   <= 1'b1;
      end else if (grant_lsb) begin
        cdb_valid    <= 1'b1;
        cdb_RoBindex <= lsb_idx_mem[lsb_head];
        cdb_value    <= lsb_val_mem[lsb_head];
        prefer_lsb   <= 1'b0;
      end else if (byp_alu) begin
        cdb_valid    <= 1'b1;
        cdb_RoBindex <= alu_RoBindex;
        cdb_value    <= alu_value;
        prefer_lsb   <= 1'b1;
      end else if (byp_lsb) begin
        cdb_valid    <= 1'b1;
        cdb_RoBindex <= lsb_RoBindex;
        cdb_value    <= lsb_value;
        prefer_lsb   <= 1'b0;
      end else begin
        cdb_valid    <= 1'b0;
        cdb_RoBindex <= '0;
        cdb_value    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Randomized and directed bench for cdb_broadcaster, checked against a queue-based model of the CDB rules.
// Honors CDB_BYPASS_EN the same way the design does.
`ifndef RoB_addr
`define RoB_addr 3:0
`endif

module tb_cdb_broadcaster;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic [`RoB_addr] idx;
    logic [31:0]      val;
  } entry_t;

  localparam int IDX_W = $bits(entry_t) - 32;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in, clear;
  logic             alu_valid, lsb_valid;
  logic [`RoB_addr] alu_RoBindex, lsb_RoBindex;
  logic [31:0]      alu_value, lsb_value;
  logic             alu_full, lsb_full;
  logic             cdb_valid;
  logic [`RoB_addr] cdb_RoBindex;
  logic [31:0]      cdb_value;

  int checks   = 0;
  int failures = 0;

  // Reference state: one queue per producer plus the side that should win the next tie.
  entry_t     alu_q[$];
  entry_t     lsb_q[$];
  bit         prefer_lsb;
  logic       exp_valid;
  logic [31:0] exp_idx;
  logic [31:0] exp_val;

  cdb_broadcaster #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .alu_valid(alu_valid), .alu_RoBindex(alu_RoBindex), .alu_value(alu_value), .alu_full(alu_full),
    .lsb_valid(lsb_valid), .lsb_RoBindex(lsb_RoBindex), .lsb_value(lsb_value), .lsb_full(lsb_full),
    .cdb_valid(cdb_valid), .cdb_RoBindex(cdb_RoBindex), .cdb_value(cdb_value)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    alu_q.delete();
    lsb_q.delete();
    prefer_lsb = 1'b0;
    exp_valid  = 1'b0;
    exp_idx    = '0;
    exp_val    = '0;
  endtask

  // Applies the bus rules to the inputs currently driven, as the next clock edge would.
  task automatic modelStep();
    bit     alu_ok, lsb_ok, byp_a, byp_l;
    entry_t a_in, l_in, e;
    if (clear) begin
      modelReset();
      return;
    end
    if (!rdy_in) return;
    a_in   = {alu_RoBindex, alu_value};
    l_in   = {lsb_RoBindex, lsb_value};
    alu_ok = alu_valid && (alu_q.size() < DEPTH);
    lsb_ok = lsb_valid && (lsb_q.size() < DEPTH);
    byp_a  = 1'b0;
    byp_l  = 1'b0;
`ifdef CDB_BYPASS_EN
    if (alu_q.size() == 0 && lsb_q.size() == 0) begin
      if (alu_valid && lsb_valid) begin
        if (prefer_lsb) byp_l = 1'b1;
        else byp_a = 1'b1;
      end else if (alu_valid) byp_a = 1'b1;
      else if (lsb_valid) byp_l = 1'b1;
    end
`endif
    exp_valid = 1'b0;
    exp_idx   = '0;
    exp_val   = '0;
    if (alu_q.size() > 0 && (lsb_q.size() == 0 || !prefer_lsb)) begin
      e = alu_q.pop_front();
      exp_valid = 1'b1; exp_idx = 32'(e.idx); exp_val = e.val; prefer_lsb = 1'b1;
    end else if (lsb_q.size() > 0) begin
      e = lsb_q.pop_front();
      exp_valid = 1'b1; exp_idx = 32'(e.idx); exp_val = e.val; prefer_lsb = 1'b0;
    end else if (byp_a) begin
      exp_valid = 1'b1; exp_idx = 32'(a_in.idx); exp_val = a_in.val; prefer_lsb = 1'b1;
    end else if (byp_l) begin
      exp_valid = 1'b1; exp_idx = 32'(l_in.idx); exp_val = l_in.val; prefer_lsb = 1'b0;
    end
    if (alu_ok && !byp_a) alu_q.push_back(a_in);
    if (lsb_ok && !byp_l) lsb_q.push_back(l_in);
  endtask

  task automatic checkAll();
    checkOutput("cdb_valid", 32'(cdb_valid), 32'(exp_valid));
    checkOutput("cdb_RoBindex", 32'(cdb_RoBindex), exp_idx);
    checkOutput("cdb_value", cdb_value, exp_val);
    checkOutput("alu_full", 32'(alu_full), 32'(alu_q.size() == DEPTH));
    checkOutput("lsb_full", 32'(lsb_full), 32'(lsb_q.size() == DEPTH));
  endtask

  // Drives one cycle of inputs at the falling edge and checks the result half a cycle after the rising edge.
  task automatic applyStimulus(input bit rdy, input bit clr,
                               input bit av, input int ai, input int aval,
                               input bit lv, input int li, input int lval);
    logic [31:0] t;
    rdy_in = rdy;
    clear  = clr;
    alu_valid = av;
    t = ai;
    alu_RoBindex = t[IDX_W-1:0];
    alu_value = aval;
    lsb_valid = lv;
    t = li;
    lsb_RoBindex = t[IDX_W-1:0];
    lsb_value = lval;
    modelStep();
    @(posedge clk_in);
    @(negedge clk_in);
    checkAll();
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic asyncReset();
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
    clear     = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(posedge clk_in);
    @(negedge clk_in);
    checkAll();
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    alu_valid = 1'b0; alu_RoBindex = '0; alu_value = '0;
    lsb_valid = 1'b0; lsb_RoBindex = '0; lsb_value = '0;
    modelReset();
    repeat (2) @(negedge clk_in);
    checkAll();
    rst_in = 1'b0;

    $display("[TB] single ALU result");
    applyStimulus(1, 0, 1, 3, 32'h1234, 0, 0, 0);
    idleCycles(3);

    $display("[TB] contention");
    applyStimulus(1, 0, 1, 1, 11, 1, 5, 55);
    applyStimulus(1, 0, 1, 2, 22, 1, 6, 66);
    idleCycles(5);

    $display("[TB] ALU FIFO full with LSB backlog");
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 1, i, 200 + i, 1, 8 + i, 300 + i);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 12, 400 + i, 0, 0, 0);
    idleCycles(12);

    $display("[TB] pointer wrap-around");
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 1, i, 100 + i, 0, 0, 0);
    idleCycles(3);

    $display("[TB] clear with buffered entries");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, i, 500 + i, 1, 4 + i, 600 + i);
    applyStimulus(1, 1, 1, 9, 999, 1, 10, 1000);
    applyStimulus(1, 0, 1, 7, 777, 0, 0, 0);
    idleCycles(4);

    $display("[TB] rdy_in low with buffered entries");
    applyStimulus(1, 0, 1, 1, 701, 1, 2, 702);
    applyStimulus(1, 0, 1, 3, 703, 1, 4, 704);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 11 + i, 800 + i, 1, 13, 900 + i);
    idleCycles(5);

    $display("[TB] asynchronous reset mid-operation");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, i, 1100 + i, 1, i, 1200 + i);
    asyncReset();
    idleCycles(2);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 2) != 0), int'($urandom_range(0, 15)), int'($urandom),
                    ($urandom_range(0, 2) != 0), int'($urandom_range(0, 15)), int'($urandom));
    end
    idleCycles(10);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
